uds_tile_sched: RTL and testbench
=================================

// Module: uds_tile_sched
// PURPOSE
//  Tile sequencer for the up/down-sample engine. Latches one job (tile count, mode, scale),
//  pulls 8x8x32b tiles from an upstream valid/ready stream and drives the engine's shift/compute
//  handshake (idata_valid, then active). It captures each engine result into a one-entry holding
//  register and forwards it downstream on valid/ready. Sits between the tile buffer and the
//  output writer; the engine itself holds no job state.
// PARAMETERS
//  A           64   words per input tile (8x8); each word is 32b
//  TILE_W      16   width of tile counter / cfg_num_tiles
//  ACT_CYC     2    cycles uds_active is held high per tile (engine compute depth)
//  WAIT_MAX    15   max cycles to wait for uds_odata_valid before flagging err
// PORTS
//  clk               in   1             clock, all logic rising-edge
//  rst_n             in   1             reset: synchronous, active-low
//  cfg_start         in   1             pulse: start job; sampled only in IDLE
//  cfg_abort         in   1             abort current job, any state
//  cfg_num_tiles     in   TILE_W        tiles in job
//  cfg_scale_factor  in   2             forwarded to engine, latched at start
//  cfg_function_mode in   2             [1]=up/down, [0]=max/avg; latched at start
//  busy              out  1             high from accepted start until DONE/abort
//  done              out  1             one-cycle pulse at job completion
//  err               out  1             sticky result-timeout flag; cleared by next accepted start
//  tile_cnt          out  TILE_W        tiles delivered downstream in current job
//  in_valid          in   1             upstream tile valid
//  in_ready          out  1             upstream tile accepted when in_valid&in_ready
//  in_data           in   A*32          upstream tile
//  uds_idata         out  A*32          tile to engine (registered)
//  uds_idata_valid   out  1             engine load strobe
//  uds_active        out  1             engine compute enable
//  uds_scale_factor  out  2             latched cfg
//  uds_function_mode out  2             latched cfg
//  uds_odata         in   2*(A-8)*32    engine result
//  uds_odata_valid   in   1             engine result strobe
//  out_valid         out  1             result valid downstream
//  out_ready         in   1             downstream accept
//  out_data          out  2*(A-8)*32    held result
//  out_last          out  1             high with out_valid on final tile of job
// BEHAVIOUR
//  Reset (rst_n low at edge): state=IDLE; every output 0, incl. uds_idata/out_data; latched cfg 0.
//  FSM: IDLE -> FETCH -> LOAD -> RUN -> WAIT -> OUT -> (FETCH | DONE) ; DONE -> IDLE.
//  IDLE : cfg_start=1 latches cfg; num_tiles=0 -> DONE directly; else -> FETCH, busy=1, err=0,
//         tile_cnt=0. cfg_start outside IDLE ignored.
//  FETCH: in_ready=1 (combinational from state). On in_valid, register in_data into uds_idata -> LOAD.
//  LOAD : exactly 1 cycle uds_idata_valid=1, uds_active=0 -> RUN.
//  RUN  : uds_active=1 for exactly ACT_CYC cycles, uds_idata_valid=0 -> WAIT.
//  WAIT : uds_active=0; wait counter counts from 0. uds_odata_valid=1 -> capture uds_odata into
//         out_data, out_valid=1 -> OUT. A strobe in RUN or in the cycle of RUN->WAIT transition is
//         also captured (engine may finish early). Counter reaches WAIT_MAX with no strobe -> err=1,
//         tile treated as delivered-empty: tile_cnt++, no out_valid, continue as if OUT accepted.
//  OUT  : hold out_valid/out_data stable until out_ready. Accept cycle: out_valid drops next cycle,
//         tile_cnt++; if tile_cnt+1==num_tiles -> DONE else -> FETCH. out_last=(tile_cnt==num_tiles-1).
//  DONE : done=1 one cycle, busy=0 -> IDLE. Results not in OUT are never driven as out_valid.
//  uds_odata_valid outside RUN/WAIT: ignored.
//  cfg_abort (priority over all but reset): next state IDLE, busy/out_valid/uds_active/
//         uds_idata_valid cleared next cycle, no done pulse, err unchanged, tile_cnt held.
//  rst_n low mid-job: same as reset, job lost.
//  Throughput: 1 tile per (1 FETCH + 1 LOAD + ACT_CYC + latency + 1) cycles min; no overlap.
//  tile_cnt wraps never: num_tiles <= 2^TILE_W-1 by construction.
// TESTING
//  T1 reset: hold rst_n=0 3 cycles with in_valid=1, cfg_start=1 -> all outputs 0, in_ready=0.
//  T2 start num_tiles=3, mode=2'b00, scale=0, engine returns 1 cycle after RUN -> 3 out beats,
//     out_last only on 3rd, done pulses once, tile_cnt=3, uds_active high 2 cycles per tile.
//  T3 out_ready low 10 cycles on tile 1 -> out_data stable, in_ready stays 0, no uds_idata_valid.
//  T4 engine never strobes on tile 2 of 3 -> err=1 after WAIT_MAX cycles, 2 beats out, done=1.
//  T5 num_tiles=0 -> done 2 cycles after start, no in_ready, no engine strobes; cfg_start while
//     busy -> ignored, latched mode unchanged.
//  T6 cfg_abort during RUN of tile 2 -> IDLE next cycle, uds_active=0, no done; new start runs clean.

Source files
------------

// File: rtl/uds_tile_sched.sv
// uds_tile_sched: one-job tile sequencer wrapped around the up/down-sample engine.
// Ports: cfg_* job control, in_* tile stream, uds_* engine handshake, out_* result stream.
module uds_tile_sched #(
  parameter int A        = 64,
  parameter int TILE_W   = 16,
  parameter int ACT_CYC  = 2,
  parameter int WAIT_MAX = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_start,
  input  logic                    cfg_abort,
  input  logic [TILE_W-1:0]       cfg_num_tiles,
  input  logic [1:0]              cfg_scale_factor,
  input  logic [1:0]              cfg_function_mode,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [TILE_W-1:0]       tile_cnt,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [A*32-1:0]         in_data,
  output logic [A*32-1:0]         uds_idata,
  output logic                    uds_idata_valid,
  output logic                    uds_active,
  output logic [1:0]              uds_scale_factor,
  output logic [1:0]              uds_function_mode,
  input  logic [2*(A-8)*32-1:0]   uds_odata,
  input  logic                    uds_odata_valid,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*(A-8)*32-1:0]   out_data,
  output logic                    out_last
);

  localparam int AW = $clog2(ACT_CYC + 1);
  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [AW-1:0] ACT_LAST  = AW'(ACT_CYC - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_RUN, S_WAIT, S_OUT, S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [TILE_W-1:0] num_tiles_q;
  logic [AW-1:0]     act_cnt;
  logic [WW-1:0]     wait_cnt;
  logic              hit;
  logic              last_tile;
  logic              strobe_ok;
  logic              timeout;

  assign last_tile = (tile_cnt + TILE_W'(1)) == num_tiles_q;
  // Engine may finish during RUN; such a result is held until WAIT.
  assign strobe_ok = uds_odata_valid &&
                     (state == S_RUN || state == S_WAIT);
  assign timeout   = (state == S_WAIT) && !hit &&
                     !uds_odata_valid && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_nx        = state;
    busy            = 1'b0;
    done            = 1'b0;
    in_ready        = 1'b0;
    uds_idata_valid = 1'b0;
    uds_active      = 1'b0;
    out_valid       = 1'b0;
    out_last        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cfg_start)
          state_nx = (cfg_num_tiles == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) state_nx = S_LOAD;
      end
      S_LOAD: begin
        busy            = 1'b1;
        uds_idata_valid = 1'b1;
        state_nx        = S_RUN;
      end
      S_RUN: begin
        busy       = 1'b1;
        uds_active = 1'b1;
        if (act_cnt == ACT_LAST) state_nx = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (hit || uds_odata_valid)
          state_nx = S_OUT;
        else if (timeout)
          state_nx = last_tile ? S_DONE : S_FETCH;
      end
      S_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = tile_cnt == (num_tiles_q - TILE_W'(1));
        if (out_ready)
          state_nx = last_tile ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (cfg_abort) state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      num_tiles_q       <= '0;
      uds_scale_factor  <= '0;
      uds_function_mode <= '0;
      err               <= 1'b0;
      tile_cnt          <= '0;
      uds_idata         <= '0;
      out_data          <= '0;
      act_cnt           <= '0;
      wait_cnt          <= '0;
      hit               <= 1'b0;
    end else begin
      state <= state_nx;
      if (cfg_abort) begin
        act_cnt  <= '0;
        wait_cnt <= '0;
        hit      <= 1'b0;
      end else begin
        if (state == S_IDLE && cfg_start) begin
          num_tiles_q       <= cfg_num_tiles;
          uds_scale_factor  <= cfg_scale_factor;
          uds_function_mode <= cfg_function_mode;
          if (cfg_num_tiles != '0) begin
            err      <= 1'b0;
            tile_cnt <= '0;
          end
        end
        if (state == S_FETCH && in_valid)
          uds_idata <= in_data;
        act_cnt  <= (state == S_RUN)  ? act_cnt + AW'(1)  : '0;
        wait_cnt <= (state == S_WAIT) ? wait_cnt + WW'(1) : '0;
        if (state == S_LOAD)
          hit <= 1'b0;
        else if (strobe_ok)
          hit <= 1'b1;
        if (strobe_ok)
          out_data <= uds_odata;
        if (timeout)
          err <= 1'b1;
        if (timeout || (state == S_OUT && out_ready))
          tile_cnt <= tile_cnt + TILE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uds_tile_sched.sv
// tb_uds_tile_sched: scoreboard bench with source, engine and sink models.
// Expected beats are queued at tile handshake and compared at result handshake.
module tb_uds_tile_sched;

  localparam int A        = 64;
  localparam int TILE_W   = 16;
  localparam int ACT_CYC  = 2;
  localparam int WAIT_MAX = 15;
  localparam int IW = A * 32;
  localparam int OW = 2 * (A - 8) * 32;

  typedef logic [OW-1:0] w_t;
  typedef struct {
    logic [OW-1:0] d;
    logic          last;
    int            job;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              cfg_start;
  logic              cfg_abort;
  logic [TILE_W-1:0] cfg_num_tiles;
  logic [1:0]        cfg_scale_factor;
  logic [1:0]        cfg_function_mode;
  logic              busy;
  logic              done;
  logic              err;
  logic [TILE_W-1:0] tile_cnt;
  logic              in_valid;
  logic              in_ready;
  logic [IW-1:0]     in_data;
  logic [IW-1:0]     uds_idata;
  logic              uds_idata_valid;
  logic              uds_active;
  logic [1:0]        uds_scale_factor;
  logic [1:0]        uds_function_mode;
  logic [OW-1:0]     uds_odata;
  logic              uds_odata_valid;
  logic              out_valid;
  logic              out_ready;
  logic [OW-1:0]     out_data;
  logic              out_last;

  int n_vec = 0;
  int n_err = 0;
  int job_id = 0;
  int job_n = 0;
  int mute_idx = -1;
  int beat_tot = 0;
  int done_tot = 0;
  int act_tot = 0;
  int load_tot = 0;
  exp_t sb[$];

  uds_tile_sched #(
    .A(A), .TILE_W(TILE_W), .ACT_CYC(ACT_CYC), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_start(cfg_start),
    .cfg_abort(cfg_abort),
    .cfg_num_tiles(cfg_num_tiles),
    .cfg_scale_factor(cfg_scale_factor),
    .cfg_function_mode(cfg_function_mode),
    .busy(busy),
    .done(done),
    .err(err),
    .tile_cnt(tile_cnt),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .uds_idata(uds_idata),
    .uds_idata_valid(uds_idata_valid),
    .uds_active(uds_active),
    .uds_scale_factor(uds_scale_factor),
    .uds_function_mode(uds_function_mode),
    .uds_odata(uds_odata),
    .uds_odata_valid(uds_odata_valid),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [OW-1:0] eng_f(logic [IW-1:0] x);
    return {x[OW-IW-1:0], ~x};
  endfunction

  task automatic chk(string tag, w_t got, w_t exp);
    n_vec++;
    if (got !== exp) begin
      int w = 0;
      for (int i = OW/32 - 1; i >= 0; i--)
        if (got[i*32 +: 32] !== exp[i*32 +: 32]) w = i;
      n_err++;
      $display("FAIL %s word%0d got %h exp %h", tag, w,
               got[w*32 +: 32], exp[w*32 +: 32]);
    end
  endtask

  // source, engine and sink models, all evaluated at the falling edge
  initial begin : bfm
    int   seen_job;
    int   tiles_acc;
    int   loads;
    int   act_seen;
    logic pend;
    logic mute;
    logic [OW-1:0] res;
    exp_t e;
    seen_job = 0; tiles_acc = 0; loads = 0; act_seen = 0;
    pend = 1'b0; mute = 1'b0; res = '0;
    uds_odata_valid = 1'b0;
    uds_odata = '0;
    in_data = '0;
    forever begin
      @(negedge clk);
      if (job_id != seen_job) begin
        seen_job = job_id;
        tiles_acc = 0;
        loads = 0;
      end
      if (done) done_tot++;
      if (uds_active) act_tot++;
      if (uds_idata_valid) load_tot++;
      if (out_valid && out_ready) begin
        beat_tot++;
        while (sb.size() > 0 && sb[0].job != job_id)
          void'(sb.pop_front());
        if (sb.size() == 0)
          chk("sb_underflow", w_t'(sb.size()), w_t'(1));
        else begin
          e = sb.pop_front();
          chk("beat_data", out_data, e.d);
          chk("beat_last", w_t'(out_last), w_t'(e.last));
        end
      end
      if (uds_odata_valid) uds_odata_valid = 1'b0;
      if (pend) begin
        uds_odata = res;
        uds_odata_valid = 1'b1;
        pend = 1'b0;
      end
      if (uds_idata_valid) begin
        res = eng_f(uds_idata);
        mute = (loads == mute_idx);
        loads++;
        act_seen = 0;
      end
      if (uds_active) begin
        act_seen++;
        if (act_seen == ACT_CYC && !mute) pend = 1'b1;
      end
      if (in_ready && in_valid) begin
        if (tiles_acc != mute_idx)
          sb.push_back('{eng_f(in_data), (tiles_acc == job_n - 1), job_id});
        tiles_acc++;
      end else if (!in_ready) begin
        for (int k = 0; k < A; k++) in_data[k*32 +: 32] = $urandom;
      end
    end
  end

  task automatic start_job(int n, logic [1:0] mode,
                           logic [1:0] scale, int mute);
    @(posedge clk); #2;
    cfg_num_tiles = TILE_W'(n);
    cfg_function_mode = mode;
    cfg_scale_factor = scale;
    mute_idx = mute;
    job_n = n;
    job_id++;
    cfg_start = 1'b1;
    @(posedge clk); #2;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(string tag, int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    chk(tag, w_t'(done), w_t'(1));
  endtask

  initial begin : main
    int b0, d0, a0, l0, n;
    logic [OW-1:0] held;
    rst_n = 1'b0;
    cfg_start = 1'b1;
    cfg_abort = 1'b0;
    cfg_num_tiles = TILE_W'(3);
    cfg_scale_factor = 2'b00;
    cfg_function_mode = 2'b00;
    in_valid = 1'b1;
    out_ready = 1'b0;

    // T1 reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", w_t'(busy), w_t'(0));
    chk("rst_done", w_t'(done), w_t'(0));
    chk("rst_err", w_t'(err), w_t'(0));
    chk("rst_tile_cnt", w_t'(tile_cnt), w_t'(0));
    chk("rst_in_ready", w_t'(in_ready), w_t'(0));
    chk("rst_idata", w_t'(uds_idata), w_t'(0));
    chk("rst_idata_valid", w_t'(uds_idata_valid), w_t'(0));
    chk("rst_active", w_t'(uds_active), w_t'(0));
    chk("rst_scale", w_t'(uds_scale_factor), w_t'(0));
    chk("rst_mode", w_t'(uds_function_mode), w_t'(0));
    chk("rst_out_valid", w_t'(out_valid), w_t'(0));
    chk("rst_out_data", out_data, w_t'(0));
    chk("rst_out_last", w_t'(out_last), w_t'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;
    cfg_start = 1'b0;
    out_ready = 1'b1;

    // T2 three tiles, prompt engine
    b0 = beat_tot; d0 = done_tot; a0 = act_tot; l0 = load_tot;
    start_job(3, 2'b00, 2'b00, -1);
    @(negedge clk);
    chk("t2_busy", w_t'(busy), w_t'(1));
    wait_done("t2_done", 300);
    @(negedge clk);
    chk("t2_beats", w_t'(beat_tot - b0), w_t'(3));
    chk("t2_done_cnt", w_t'(done_tot - d0), w_t'(1));
    chk("t2_tile_cnt", w_t'(tile_cnt), w_t'(3));
    chk("t2_active_cyc", w_t'(act_tot - a0), w_t'(3 * ACT_CYC));
    chk("t2_loads", w_t'(load_tot - l0), w_t'(3));
    chk("t2_busy_end", w_t'(busy), w_t'(0));

    // T3 downstream stall on first tile
    b0 = beat_tot;
    @(posedge clk); #2;
    out_ready = 1'b0;
    start_job(2, 2'b01, 2'b10, -1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    chk("t3_out_valid", w_t'(out_valid), w_t'(1));
    held = out_data;
    repeat (10) begin
      @(negedge clk);
      chk("t3_hold_data", out_data, held);
      chk("t3_hold_valid", w_t'(out_valid), w_t'(1));
      chk("t3_in_ready", w_t'(in_ready), w_t'(0));
      chk("t3_idata_valid", w_t'(uds_idata_valid), w_t'(0));
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_done("t3_done", 300);
    @(negedge clk);
    chk("t3_beats", w_t'(beat_tot - b0), w_t'(2));

    // T4 engine silent on tile 2 of 3
    b0 = beat_tot; d0 = done_tot;
    start_job(3, 2'b01, 2'b01, 1);
    wait_done("t4_done", 400);
    @(negedge clk);
    chk("t4_err", w_t'(err), w_t'(1));
    chk("t4_beats", w_t'(beat_tot - b0), w_t'(2));
    chk("t4_done_cnt", w_t'(done_tot - d0), w_t'(1));
    chk("t4_tile_cnt", w_t'(tile_cnt), w_t'(3));

    // T6 abort during RUN of tile 2, then a clean job
    b0 = beat_tot; d0 = done_tot;
    start_job(3, 2'b00, 2'b00, -1);
    @(negedge clk);
    chk("t6_err_clr", w_t'(err), w_t'(0));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(uds_active && tile_cnt == TILE_W'(1)) && n < 200);
    chk("t6_run2", w_t'(uds_active), w_t'(1));
    @(posedge clk); #2;
    cfg_abort = 1'b1;
    @(posedge clk); #2;
    cfg_abort = 1'b0;
    @(negedge clk);
    chk("t6_busy", w_t'(busy), w_t'(0));
    chk("t6_active", w_t'(uds_active), w_t'(0));
    chk("t6_out_valid", w_t'(out_valid), w_t'(0));
    chk("t6_in_ready", w_t'(in_ready), w_t'(0));
    chk("t6_tile_cnt", w_t'(tile_cnt), w_t'(1));
    repeat (20) @(negedge clk);
    chk("t6_no_done", w_t'(done_tot - d0), w_t'(0));
    chk("t6_beats", w_t'(beat_tot - b0), w_t'(1));
    b0 = beat_tot; d0 = done_tot;
    start_job(2, 2'b11, 2'b10, -1);
    @(negedge clk);
    chk("t6_mode", w_t'(uds_function_mode), w_t'(3));
    chk("t6_scale", w_t'(uds_scale_factor), w_t'(2));
    wait_done("t6_done", 300);
    @(negedge clk);
    chk("t6_beats2", w_t'(beat_tot - b0), w_t'(2));
    chk("t6_tile_cnt2", w_t'(tile_cnt), w_t'(2));
    chk("t6_done_cnt", w_t'(done_tot - d0), w_t'(1));

    // T5 empty job, then start while busy
    b0 = beat_tot; d0 = done_tot; l0 = load_tot;
    start_job(0, 2'b01, 2'b11, -1);
    @(negedge clk);
    chk("t5_done", w_t'(done), w_t'(1));
    chk("t5_busy", w_t'(busy), w_t'(0));
    chk("t5_in_ready", w_t'(in_ready), w_t'(0));
    chk("t5_mode0", w_t'(uds_function_mode), w_t'(1));
    @(negedge clk);
    chk("t5_done_pulse", w_t'(done), w_t'(0));
    chk("t5_loads0", w_t'(load_tot - l0), w_t'(0));
    start_job(1, 2'b10, 2'b01, -1);
    @(posedge clk); #2;
    cfg_function_mode = 2'b01;
    cfg_scale_factor = 2'b11;
    cfg_num_tiles = TILE_W'(5);
    cfg_start = 1'b1;
    @(posedge clk); #2;
    cfg_start = 1'b0;
    @(negedge clk);
    chk("t5_mode_kept", w_t'(uds_function_mode), w_t'(2));
    chk("t5_scale_kept", w_t'(uds_scale_factor), w_t'(1));
    wait_done("t5_done1", 300);
    @(negedge clk);
    chk("t5_beats", w_t'(beat_tot - b0), w_t'(1));
    chk("t5_loads", w_t'(load_tot - l0), w_t'(1));
    chk("t5_done_cnt", w_t'(done_tot - d0), w_t'(2));
    chk("t5_tile_cnt", w_t'(tile_cnt), w_t'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
